mem_burst_reader: RTL and testbench

MEM_BURST_READER -- requirements
Module: mem_burst_reader

---
 rtl/mem_burst_reader_if.sv | 42 ++++
 rtl/mem_burst_reader.sv | 157 +++++++++++++++
 tb/tb_mem_burst_reader.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_burst_reader_if.sv
// Bus bundle for mem_burst_reader: burst command, memory-mux port and read stream.
// checksum_o exists only when MEM_BURST_READER_CHECKSUM_EN is defined.
interface mem_burst_reader_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 16
);
    logic              start_i;
    logic [ADDR_W-1:0] start_addr_i;
    logic [ADDR_W:0]   len_i;
    logic              abort_i;
    logic              grant_i;
    logic [ADDR_W-1:0] addr_o;
    logic              we_o;
    logic [DATA_W-1:0] data_o;
    logic [DATA_W-1:0] mem_data_i;
    logic [DATA_W-1:0] rd_data_o;
    logic              rd_valid_o;
    logic              rd_ready_i;
    logic              busy_o;
    logic              done_o;
`ifdef MEM_BURST_READER_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_o;
`endif

    // A word moves on the read stream in every cycle where rd_valid_o && rd_ready_i;
    // rd_valid_o and rd_data_o stay stable until that happens or the burst is aborted.
    modport master (
`ifdef MEM_BURST_READER_CHECKSUM_EN
        output checksum_o,
`endif
        input  start_i, start_addr_i, len_i, abort_i, grant_i, mem_data_i, rd_ready_i,
        output addr_o, we_o, data_o, rd_data_o, rd_valid_o, busy_o, done_o
    );

    modport slave (
`ifdef MEM_BURST_READER_CHECKSUM_EN
        input  checksum_o,
`endif
        output start_i, start_addr_i, len_i, abort_i, grant_i, mem_data_i, rd_ready_i,
        input  addr_o, we_o, data_o, rd_data_o, rd_valid_o, busy_o, done_o
    );
endinterface

// File: rtl/mem_burst_reader.sv
// Burst reader: streams len words from a shared memory port through a 2-entry FIFO.
// Optional running checksum of transferred words under MEM_BURST_READER_CHECKSUM_EN.
module mem_burst_reader #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 16
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    mem_burst_reader_if.master  bus,
    output logic [1:0]          state_o
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [ADDR_W:0]   LEN_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] next_addr_q, next_addr_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   issue_left_q, issue_left_d;
    logic [ADDR_W:0]   xfer_left_q, xfer_left_d;
    logic              inflight_q;
    logic              zero_done_q, zero_done_d;

    logic [DATA_W-1:0] fifo_q [2];
    logic              wr_ptr_q, rd_ptr_q;
    logic [1:0]        count_q;

    logic              start_ok, aborting, fire, issue, room, last_fire;
    logic [1:0]        occ_sum;

    assign start_ok  = (state_q == IDLE) && bus.start_i && !bus.abort_i;
    assign aborting  = (state_q != IDLE) && bus.abort_i;
    assign fire      = bus.rd_valid_o && bus.rd_ready_i;
    assign occ_sum   = count_q + {1'b0, inflight_q};
    // A word popped this cycle frees its slot in time for a new issue, which keeps 1 word/cycle.
    assign room      = (occ_sum < 2'd2) || ((occ_sum == 2'd2) && fire);
    assign issue     = (state_q == READ) && !bus.abort_i && bus.grant_i && room &&
                       (issue_left_q != '0);
    assign last_fire = (state_q == DRAIN) && fire && !bus.abort_i && (xfer_left_q == LEN_ONE);

    assign bus.addr_o     = issue ? next_addr_q : addr_q;
    assign bus.we_o       = 1'b0;
    assign bus.data_o     = '0;
    assign bus.rd_valid_o = (count_q != 2'd0);
    assign bus.rd_data_o  = fifo_q[rd_ptr_q];
    assign bus.busy_o     = (state_q != IDLE);
    assign bus.done_o     = zero_done_q || last_fire;
    assign state_o        = state_q;

    always_comb begin
        state_d      = state_q;
        next_addr_d  = next_addr_q;
        issue_left_d = issue_left_q;
        xfer_left_d  = xfer_left_q;
        zero_done_d  = 1'b0;
        if (issue) begin
            next_addr_d  = next_addr_q + ADDR_ONE;
            issue_left_d = issue_left_q - LEN_ONE;
        end
        if (fire) begin
            xfer_left_d = xfer_left_q - LEN_ONE;
        end
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    next_addr_d  = bus.start_addr_i;
                    issue_left_d = bus.len_i;
                    xfer_left_d  = bus.len_i;
                    if (bus.len_i == '0) begin
                        zero_done_d = 1'b1;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                if (bus.abort_i) begin
                    state_d = IDLE;
                end else if (issue && (issue_left_q == LEN_ONE)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (bus.abort_i || last_fire) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= IDLE;
            next_addr_q  <= '0;
            addr_q       <= '0;
            issue_left_q <= '0;
            xfer_left_q  <= '0;
            inflight_q   <= 1'b0;
            zero_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            next_addr_q  <= next_addr_d;
            addr_q       <= bus.addr_o;
            issue_left_q <= issue_left_d;
            xfer_left_q  <= xfer_left_d;
            inflight_q   <= issue;
            zero_done_q  <= zero_done_d;
        end
    end

    // The in-flight word lands regardless of grant_i; an abort drops it along with the FIFO.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < 2; i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (aborting) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (inflight_q) begin
                fifo_q[wr_ptr_q] <= bus.mem_data_i;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (fire) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, inflight_q} - {1'b0, fire};
        end
    end

`ifdef MEM_BURST_READER_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            checksum_q <= '0;
        end else if (start_ok) begin
            checksum_q <= '0;
        end else if (fire) begin
            checksum_q <= checksum_q + bus.rd_data_o;
        end
    end

    assign bus.checksum_o = checksum_q;
`endif
endmodule

// File: tb/tb_mem_burst_reader.sv
// Randomized bench for mem_burst_reader: a memory responder, a per-burst expected-word
// queue built from start address and length, and cycle-level done/latency checks.
module tb_mem_burst_reader;
    localparam int ADDR_W = 14;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 1 << ADDR_W;

    logic        clk;
    logic        rst_n;
    logic [1:0]  state_dbg;
    logic [15:0] mem [DEPTH];
    int          n_cmp;
    int          n_err;

    mem_burst_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_burst_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus),
        .state_o (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory answers one cycle after the address; garbage when the port was not granted.
    always @(posedge clk) begin
        if (bus.grant_i) bus.mem_data_i <= mem[bus.addr_o];
        else             bus.mem_data_i <= 16'($urandom);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // rmode: 0 ready high, 1 random. gmode: 0 grant high, 1 random, 2 low for 3 cycles.
    task automatic run_burst(input logic [13:0] a, input int n, input int rmode,
                             input int gmode, input int abort_after);
        logic [15:0] exp_q[$];
        logic [15:0] exp_sum;
        logic [15:0] w;
        logic [13:0] ai;
        int          cyc, xfers, first_fire, last_fire, dones;
        bit          fin, aborted, fire, exp_done;
        exp_sum = '0;
        for (int i = 0; i < n; i++) begin
            ai = a + 14'(i);
            exp_q.push_back(mem[ai]);
            exp_sum = exp_sum + mem[ai];
        end
        cyc = 0; xfers = 0; first_fire = -1; last_fire = -1; dones = 0;
        fin = 0; aborted = 0;
        @(posedge clk); #1;
        bus.start_i      = 1'b1;
        bus.start_addr_i = a;
        bus.len_i        = 15'(n);
        bus.rd_ready_i   = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        bus.grant_i      = (gmode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        while (!fin && cyc < 400) begin
            @(negedge clk);
            if (cyc == 0) chk("busy_before_accept", bus.busy_o, 0);
            fire = bus.rd_valid_o && bus.rd_ready_i;
            if (n == 0) begin
                exp_done = (cyc == 1);
                chk("len0_valid", bus.rd_valid_o, 0);
            end else begin
                exp_done = fire && (exp_q.size() == 1) && !bus.abort_i;
            end
            if (fire) begin
                if (exp_q.size() == 0) begin
                    chk("extra_word", 1, 0);
                end else begin
                    w = exp_q.pop_front();
                    chk("data", bus.rd_data_o, w);
                end
                xfers++;
                if (first_fire < 0) first_fire = cyc;
                last_fire = cyc;
            end
            chk("done", bus.done_o, exp_done);
            if (bus.done_o) dones++;
`ifdef MEM_BURST_READER_CHECKSUM_EN
            if (exp_done) chk("checksum", bus.checksum_o, exp_sum);
`endif
            if (exp_done) fin = 1;
            if (bus.abort_i) begin
                fin = 1;
                aborted = 1;
            end
            if (!fin) begin
                @(posedge clk); #1;
                cyc++;
                bus.start_i    = 1'b0;
                bus.abort_i    = 1'b0;
                bus.rd_ready_i = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
                case (gmode)
                    1:       bus.grant_i = 1'($urandom_range(0, 1));
                    2:       bus.grant_i = !(cyc >= 3 && cyc < 6);
                    default: bus.grant_i = 1'b1;
                endcase
                if (rmode != 0 && cyc == 4) begin
                    bus.start_i      = 1'b1;
                    bus.start_addr_i = ~a;
                    bus.len_i        = 15'd3;
                end
                if (abort_after >= 0 && xfers == abort_after) begin
                    bus.abort_i    = 1'b1;
                    bus.rd_ready_i = 1'b0;
                end
            end
        end
        if (!fin) chk("burst_timeout", 0, 1);
        @(posedge clk); #1;
        bus.start_i    = 1'b0;
        bus.abort_i    = 1'b0;
        bus.rd_ready_i = 1'b1;
        bus.grant_i    = 1'b1;
        @(negedge clk);
        chk("busy_after_end", bus.busy_o, 0);
        chk("valid_after_end", bus.rd_valid_o, 0);
        chk("done_after_end", bus.done_o, 0);
        chk("done_count", dones, aborted ? 0 : 1);
        if (aborted) begin
            chk("abort_xfers", xfers, abort_after);
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                chk("abort_quiet", {bus.done_o, bus.rd_valid_o, bus.busy_o}, 0);
            end
        end else begin
            chk("words_left", exp_q.size(), 0);
            if (rmode == 0 && gmode == 0 && n > 0) begin
                chk("first_valid_cycle", first_fire, 3);
                chk("back_to_back", last_fire - first_fire, n - 1);
            end
        end
        chk("we_const", {bus.we_o, bus.data_o}, 0);
    endtask

    task automatic reset_mid_burst();
        @(posedge clk); #1;
        bus.start_i      = 1'b1;
        bus.start_addr_i = 14'h0200;
        bus.len_i        = 15'd10;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_valid", bus.rd_valid_o, 0);
        chk("rst_data", bus.rd_data_o, 0);
        chk("rst_addr", bus.addr_o, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("post_rst_quiet", {bus.done_o, bus.rd_valid_o, bus.busy_o}, 0);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        for (int i = 0; i < DEPTH; i++) mem[i] = 16'($urandom);
        mem[14'h0100] = 16'hFFFF;
        mem[14'h0101] = 16'h0002;
        mem[14'h0102] = 16'h0003;
        rst_n            = 1'b0;
        bus.start_i      = 1'b0;
        bus.start_addr_i = '0;
        bus.len_i        = '0;
        bus.abort_i      = 1'b0;
        bus.grant_i      = 1'b1;
        bus.rd_ready_i   = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", bus.busy_o, 0);
        chk("reset_valid", bus.rd_valid_o, 0);
        chk("reset_done", bus.done_o, 0);
        chk("reset_addr", bus.addr_o, 0);
        chk("reset_data", bus.rd_data_o, 0);
        chk("reset_state", state_dbg, 0);
        chk("reset_we", {bus.we_o, bus.data_o}, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        run_burst(14'h0010, 4, 0, 0, -1);
        run_burst(14'h3FFE, 4, 0, 0, -1);
        run_burst(14'h0040, 8, 1, 2, -1);
        run_burst(14'h0123, 0, 0, 0, -1);
        run_burst(14'h0500, 16, 0, 0, 5);
        run_burst(14'h0600, 6, 0, 0, -1);
        run_burst(14'h0100, 3, 0, 0, -1);

        // abort and start together while idle: start must be ignored
        @(posedge clk); #1;
        bus.start_i = 1'b1;
        bus.abort_i = 1'b1;
        bus.len_i   = 15'd5;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        bus.abort_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("abort_start_idle", {bus.done_o, bus.rd_valid_o, bus.busy_o}, 0);
        end

        for (int r = 0; r < 8; r++) begin
            run_burst(14'($urandom_range(0, DEPTH - 1)), $urandom_range(1, 20), 1, 1, -1);
        end
        run_burst(14'h3FF0, 16384, 0, 0, 7);
        reset_mid_burst();
        run_burst(14'h0777, 5, 0, 0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
